run_ctrl: RTL and testbench
===========================

# run_ctrl

Program-run controller between the bench/host handshake (`Start`/`Ack`) and the CPU core. It holds the core stalled while data memory is loaded and presets the PC to the selected program's entry address. It then releases the core, counts execution cycles, and raises `Ack` when the core retires its halt instruction. An optional watchdog ends runaway programs.

## Interface
Parameters:
- `ADDR_W`, 10: instruction-address width.
- `CNT_W`, 32: cycle-counter width.
- `PROG_ADDR0`..`PROG_ADDR3`, 0 / 64 / 128 / 192: entry addresses selected by `ProgSel`.
- `WDOG_LIMIT`, 100000: RUN-cycle limit. Used only with the watchdog compiled in.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Start` in 1: level request. High means load/arm; its fall launches the program.
- `ProgSel` in 2: program select, sampled on IDLE/DONE→ARMED.
- `Halt` in 1: core retired its halt instruction this cycle.
- `CoreEn` out 1: core advances only when high.
- `PcLoad` out 1: core loads `PcStart` into the PC.
- `PcStart` out ADDR_W: entry address.
- `Ack` out 1: program complete (the `done` seen by the bench).
- `CycleCount` out CNT_W: RUN cycles of the last/current run.
- `Timeout` out 1: last run ended by watchdog.

## Operation
- States: IDLE, ARMED, RUN, DONE.
- IDLE:
  - All enables low.
  - `Start`=1 → ARMED. Latch `ProgSel` and clear `CycleCount` and `Timeout`.
- ARMED:
  - `CoreEn`=0, `PcLoad`=1, `PcStart`=PROG_ADDRn, all held every cycle.
  - `Start`=0 → RUN.
- RUN:
  - `CoreEn`=1, `PcLoad`=0.
  - `CycleCount` increments each cycle and saturates at all-ones.
  - `Halt`=1 → DONE.
  - `Start`=1 → ARMED. This aborts the run and re-latches `ProgSel`. Start wins over a simultaneous `Halt`.
- DONE:
  - `Ack`=1, `CoreEn`=0, `CycleCount` frozen.
  - `Start`=1 → ARMED. `Ack` falls on the same edge.
- `Start` is level-sensitive. If `Start` is already high when `Reset` releases, the next edge goes IDLE→ARMED.
- `Halt` is ignored outside RUN.
- `ProgSel` changes outside the IDLE/DONE→ARMED edge have no effect.

## Timing
- Reset values: state IDLE. `CoreEn`, `PcLoad`, `Ack` and `Timeout` = 0. `PcStart` and `CycleCount` = 0.
- All outputs are registered, so each updates on the edge that enters its state.
- `Start` falls at edge k (sampled low at k) → first `CoreEn`=1 cycle follows edge k.
- `CycleCount` counts edges taken while in RUN, including the edge that samples `Halt`.
- `Halt` sampled high at edge h → `Ack`=1 and `CoreEn`=0 from edge h. The core therefore executes no instruction after the halt.
- `Reset` mid-run: all outputs clear immediately (asynchronously) and the state returns to IDLE. No partial `Ack` is produced.

## Configuration
- Macro `RUN_CTRL_WDOG_EN`, defined:
  - In RUN, when `CycleCount` reaches WDOG_LIMIT and `Halt` is 0, go to DONE with `Timeout`=1 and `Ack`=1.
  - `Timeout` clears on the next entry to ARMED.
  - `Halt` on the limit cycle wins, so `Timeout` stays 0.
- Macro not defined:
  - `Timeout` is tied to 0 and WDOG_LIMIT is unused.
  - A core that never halts leaves the controller in RUN indefinitely, with `CycleCount` saturated.

## Structure
- Shared `cpu_pkg` holds:
  - the `run_state_t` enum (IDLE, ARMED, RUN, DONE);
  - the `PROG_SEL_W`=2 constant;
  - the default entry-address constants.
- One sub-module, `run_counter`:
  - synchronous clear, enable, saturating increment;
  - terminal-value compare output used by the watchdog.
- The FSM and the output registers live in `run_ctrl`.

## Test plan
- **Reset with `Start` high.** Hold `Start`=1 across reset release with `ProgSel`=1. Expect ARMED after the first edge, `PcLoad`=1, `PcStart`=64, `CoreEn`=0.
- **Normal run.** Drop `Start` at edge k and pulse `Halt` 37 edges later. Expect `CycleCount`=37, `Ack`=1 from the `Halt` edge, `CoreEn`=0 thereafter, `Ack` held until `Start` rises again.
- **Abort and restart.** Raise `Start` during RUN together with `Halt`. Expect ARMED with `Ack`=0, `CycleCount` cleared, new `ProgSel` honoured.
- **Stray `Halt`.** Pulse `Halt` in IDLE, ARMED and DONE. Expect no state change, no `Ack` toggle, count unchanged.
- **Watchdog (`RUN_CTRL_WDOG_EN`).** Set WDOG_LIMIT=50 and never assert `Halt`. Expect `Ack`=1 and `Timeout`=1 with `CycleCount`=50. A following clean run clears `Timeout`.
- **Asynchronous reset mid-RUN.** Assert `Reset` between clock edges. Expect `CoreEn`, `Ack` and `CycleCount` at 0 before the next edge, and the state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the program-run controller.
//   run_state_t    : controller states (IDLE, ARMED, RUN, DONE)
//   PROG_SEL_W     : width of the program-select field
//   PROG_ADDRn_DEF : default program entry addresses
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } run_state_t;

   localparam int PROG_SEL_W = 2;

   localparam int PROG_ADDR0_DEF = 0;
   localparam int PROG_ADDR1_DEF = 64;
   localparam int PROG_ADDR2_DEF = 128;
   localparam int PROG_ADDR3_DEF = 192;

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host handshake and core-control bundle of run_ctrl.
//   Start, ProgSel, Halt        : host/core requests into the controller
//   CoreEn, PcLoad, PcStart     : core control out of the controller
//   Ack, CycleCount, Timeout    : run status back to the host
// Modports: master = host/core side, slave = controller side.
interface run_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 32
);
   import cpu_pkg::*;

   logic                  Start;
   logic [PROG_SEL_W-1:0] ProgSel;
   logic                  Halt;
   logic                  CoreEn;
   logic                  PcLoad;
   logic [ADDR_W-1:0]     PcStart;
   logic                  Ack;
   logic [CNT_W-1:0]      CycleCount;
   logic                  Timeout;

   modport master (
      output Start, ProgSel, Halt,
      input  CoreEn, PcLoad, PcStart, Ack, CycleCount, Timeout
   );

   modport slave (
      input  Start, ProgSel, Halt,
      output CoreEn, PcLoad, PcStart, Ack, CycleCount, Timeout
   );

endinterface

// File: rtl/run_counter.sv
// run_counter: saturating cycle counter with synchronous clear.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   clr_i        : synchronous clear (wins over en_i)
//   en_i         : count one per edge, holding at all-ones
//   count_o      : registered count
//   at_term_o    : count_o equals TERM (next enabled edge reaches TERM+1)
module run_counter #(
   parameter int                CNT_W = 32,
   parameter logic [CNT_W-1:0]  TERM  = {CNT_W{1'b1}}
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             at_term_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {CNT_W{1'b0}};
      end else if (en_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign at_term_o = (count_q == TERM);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: program-run controller between the host Start/Ack handshake
// and the CPU core. Stalls the core and presets the PC while Start is high,
// releases the core when Start falls, counts RUN cycles and acknowledges
// when the core retires its halt instruction.
//   Clk, Reset : clock and asynchronous active-high reset
//   bus        : run_ctrl_if slave (Start, ProgSel, Halt in;
//                CoreEn, PcLoad, PcStart, Ack, CycleCount, Timeout out)
// Optional feature: define RUN_CTRL_WDOG_EN to end a run after WDOG_LIMIT
// RUN cycles with Timeout=1; otherwise Timeout stays 0.
module run_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int CNT_W      = 32,
   parameter int PROG_ADDR0 = PROG_ADDR0_DEF,
   parameter int PROG_ADDR1 = PROG_ADDR1_DEF,
   parameter int PROG_ADDR2 = PROG_ADDR2_DEF,
   parameter int PROG_ADDR3 = PROG_ADDR3_DEF,
   parameter int WDOG_LIMIT = 100000
) (
   input  logic        Clk,
   input  logic        Reset,
   run_ctrl_if.slave   bus
);

   // The watchdog fires on the edge that takes the count to WDOG_LIMIT,
   // so the compare looks for one below the limit.
   localparam logic [CNT_W-1:0] WDOG_TERM = CNT_W'(WDOG_LIMIT - 1);

   run_state_t        state_q;
   logic              core_en_q;
   logic              pc_load_q;
   logic [ADDR_W-1:0] pc_start_q;
   logic              ack_q;
   logic              timeout_q;

   logic              arm_s;
   logic              cnt_en_s;
   logic              cnt_at_term_s;
   logic              wdog_hit_s;
   logic [CNT_W-1:0]  cnt_value_s;

   function automatic logic [ADDR_W-1:0] entry_addr(input logic [PROG_SEL_W-1:0] sel);
      logic [ADDR_W-1:0] addr;
      case (sel)
         2'd0:    addr = ADDR_W'(PROG_ADDR0);
         2'd1:    addr = ADDR_W'(PROG_ADDR1);
         2'd2:    addr = ADDR_W'(PROG_ADDR2);
         2'd3:    addr = ADDR_W'(PROG_ADDR3);
         default: addr = ADDR_W'(PROG_ADDR0);
      endcase
      return addr;
   endfunction

   // Arm request and counter enable derived from the current state.
   always_comb begin
      arm_s    = 1'b0;
      cnt_en_s = 1'b0;
      case (state_q)
         IDLE:    arm_s = bus.Start;
         ARMED:   arm_s = 1'b0;
         RUN: begin
            arm_s    = bus.Start;
            cnt_en_s = 1'b1;
         end
         DONE:    arm_s = bus.Start;
         default: arm_s = 1'b0;
      endcase
   end

   run_counter #(
      .CNT_W (CNT_W),
      .TERM  (WDOG_TERM)
   ) u_run_counter (
      .clk_i     (Clk),
      .rst_i     (Reset),
      .clr_i     (arm_s),
      .en_i      (cnt_en_s),
      .count_o   (cnt_value_s),
      .at_term_o (cnt_at_term_s)
   );

`ifdef RUN_CTRL_WDOG_EN
   assign wdog_hit_s = cnt_at_term_s;
`else
   logic unused_term_s;
   assign unused_term_s = cnt_at_term_s;
   assign wdog_hit_s    = 1'b0;
`endif

   // Controller FSM with registered outputs; arming wins over Halt/watchdog.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         core_en_q  <= 1'b0;
         pc_load_q  <= 1'b0;
         pc_start_q <= {ADDR_W{1'b0}};
         ack_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else if (arm_s) begin
         state_q    <= ARMED;
         core_en_q  <= 1'b0;
         pc_load_q  <= 1'b1;
         pc_start_q <= entry_addr(bus.ProgSel);
         ack_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         case (state_q)
            ARMED: begin
               if (!bus.Start) begin
                  state_q   <= RUN;
                  core_en_q <= 1'b1;
                  pc_load_q <= 1'b0;
               end
            end
            RUN: begin
               if (bus.Halt) begin
                  state_q   <= DONE;
                  core_en_q <= 1'b0;
                  ack_q     <= 1'b1;
               end else if (wdog_hit_s) begin
                  state_q   <= DONE;
                  core_en_q <= 1'b0;
                  ack_q     <= 1'b1;
                  timeout_q <= 1'b1;
               end
            end
            IDLE, DONE: begin
               state_q <= state_q;
            end
            default: begin
               state_q   <= IDLE;
               core_en_q <= 1'b0;
               pc_load_q <= 1'b0;
               ack_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.CoreEn     = core_en_q;
   assign bus.PcLoad     = pc_load_q;
   assign bus.PcStart    = pc_start_q;
   assign bus.Ack        = ack_q;
   assign bus.CycleCount = cnt_value_s;
   assign bus.Timeout    = timeout_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl.
module tb_run_ctrl;

   logic Clk;
   logic Reset;
   int   n_checks;
   int   n_errors;

   run_ctrl_if #(.ADDR_W(10), .CNT_W(32)) bus ();

   run_ctrl #(
      .ADDR_W     (10),
      .CNT_W      (32),
      .PROG_ADDR0 (0),
      .PROG_ADDR1 (64),
      .PROG_ADDR2 (128),
      .PROG_ADDR3 (192),
      .WDOG_LIMIT (50)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      Reset        = 1'b1;
      bus.Start    = 1'b1;
      bus.ProgSel  = 2'd1;
      bus.Halt     = 1'b0;

      // Reset values while reset is held, with Start already high.
      step(2);
      check_val("rst_coreen",  {31'd0, bus.CoreEn},  32'd0);
      check_val("rst_pcload",  {31'd0, bus.PcLoad},  32'd0);
      check_val("rst_ack",     {31'd0, bus.Ack},     32'd0);
      check_val("rst_timeout", {31'd0, bus.Timeout}, 32'd0);
      check_val("rst_pcstart", {22'd0, bus.PcStart}, 32'd0);
      check_val("rst_count",   bus.CycleCount,       32'd0);

      // Release reset between edges: first edge arms program 1.
      #4;
      Reset = 1'b0;
      step(1);
      check_val("arm_pcload",  {31'd0, bus.PcLoad},  32'd1);
      check_val("arm_pcstart", {22'd0, bus.PcStart}, 32'd64);
      check_val("arm_coreen",  {31'd0, bus.CoreEn},  32'd0);

      // Stray Halt in ARMED and a ProgSel change while armed: no effect.
      bus.Halt    = 1'b1;
      bus.ProgSel = 2'd2;
      step(1);
      bus.Halt = 1'b0;
      check_val("armhalt_pcload",  {31'd0, bus.PcLoad},  32'd1);
      check_val("armhalt_pcstart", {22'd0, bus.PcStart}, 32'd64);
      check_val("armhalt_count",   bus.CycleCount,       32'd0);
      check_val("armhalt_ack",     {31'd0, bus.Ack},     32'd0);

      // Normal run: Start drops at edge k, Halt sampled at edge k+37.
      bus.Start = 1'b0;
      step(1);
      check_val("run_coreen", {31'd0, bus.CoreEn}, 32'd1);
      check_val("run_pcload", {31'd0, bus.PcLoad}, 32'd0);
      check_val("run_count0", bus.CycleCount,      32'd0);
      step(36);
      check_val("run_count36", bus.CycleCount,      32'd36);
      check_val("run_ack0",    {31'd0, bus.Ack},    32'd0);
      bus.Halt = 1'b1;
      step(1);
      bus.Halt = 1'b0;
      check_val("done_ack",    {31'd0, bus.Ack},    32'd1);
      check_val("done_coreen", {31'd0, bus.CoreEn}, 32'd0);
      check_val("done_count",  bus.CycleCount,      32'd37);
      step(3);
      check_val("done_hold_ack",   {31'd0, bus.Ack}, 32'd1);
      check_val("done_hold_count", bus.CycleCount,   32'd37);

      // Stray Halt in DONE.
      bus.Halt = 1'b1;
      step(1);
      bus.Halt = 1'b0;
      check_val("donehalt_ack",    {31'd0, bus.Ack},    32'd1);
      check_val("donehalt_count",  bus.CycleCount,      32'd37);
      check_val("donehalt_coreen", {31'd0, bus.CoreEn}, 32'd0);

      // Restart from DONE with program 3: Ack falls on the arming edge.
      bus.ProgSel = 2'd3;
      bus.Start   = 1'b1;
      step(1);
      check_val("rearm_ack",     {31'd0, bus.Ack},     32'd0);
      check_val("rearm_pcload",  {31'd0, bus.PcLoad},  32'd1);
      check_val("rearm_pcstart", {22'd0, bus.PcStart}, 32'd192);
      check_val("rearm_count",   bus.CycleCount,       32'd0);

      // Abort: Start and Halt together in RUN, Start wins.
      bus.Start = 1'b0;
      step(5);
      check_val("abort_pre_count", bus.CycleCount, 32'd4);
      bus.ProgSel = 2'd2;
      bus.Start   = 1'b1;
      bus.Halt    = 1'b1;
      step(1);
      bus.Halt = 1'b0;
      check_val("abort_ack",     {31'd0, bus.Ack},     32'd0);
      check_val("abort_pcload",  {31'd0, bus.PcLoad},  32'd1);
      check_val("abort_coreen",  {31'd0, bus.CoreEn},  32'd0);
      check_val("abort_pcstart", {22'd0, bus.PcStart}, 32'd128);
      check_val("abort_count",   bus.CycleCount,       32'd0);

      // Runaway program: never halts.
      bus.Start = 1'b0;
      step(1);
`ifdef RUN_CTRL_WDOG_EN
      step(49);
      check_val("wdog_pre_ack",   {31'd0, bus.Ack}, 32'd0);
      check_val("wdog_pre_count", bus.CycleCount,   32'd49);
      step(1);
      check_val("wdog_ack",     {31'd0, bus.Ack},     32'd1);
      check_val("wdog_timeout", {31'd0, bus.Timeout}, 32'd1);
      check_val("wdog_count",   bus.CycleCount,       32'd50);
      check_val("wdog_coreen",  {31'd0, bus.CoreEn},  32'd0);
      bus.Start = 1'b1;
      step(1);
      check_val("wdog_clr_timeout", {31'd0, bus.Timeout}, 32'd0);
      bus.Start = 1'b0;
      step(4);
      bus.Halt = 1'b1;
      step(1);
      bus.Halt = 1'b0;
      check_val("clean_ack",     {31'd0, bus.Ack},     32'd1);
      check_val("clean_count",   bus.CycleCount,       32'd4);
      check_val("clean_timeout", {31'd0, bus.Timeout}, 32'd0);
`else
      step(60);
      check_val("nowdog_ack",     {31'd0, bus.Ack},     32'd0);
      check_val("nowdog_timeout", {31'd0, bus.Timeout}, 32'd0);
      check_val("nowdog_count",   bus.CycleCount,       32'd60);
      check_val("nowdog_coreen",  {31'd0, bus.CoreEn},  32'd1);
      bus.Halt = 1'b1;
      step(1);
      bus.Halt = 1'b0;
      check_val("nowdog_done_ack",   {31'd0, bus.Ack}, 32'd1);
      check_val("nowdog_done_count", bus.CycleCount,   32'd61);
`endif

      // Enter RUN again, then assert Reset between edges.
      bus.Start = 1'b1;
      step(1);
      bus.Start = 1'b0;
      step(6);
      check_val("pre_rst_count", bus.CycleCount, 32'd5);
      #3;
      Reset = 1'b1;
      #1;
      check_val("async_coreen", {31'd0, bus.CoreEn}, 32'd0);
      check_val("async_ack",    {31'd0, bus.Ack},    32'd0);
      check_val("async_count",  bus.CycleCount,      32'd0);
      check_val("async_pcload", {31'd0, bus.PcLoad}, 32'd0);
      #2;
      Reset = 1'b0;

      // Back in IDLE: stray Halt does nothing, then Start arms program 2.
      bus.Halt = 1'b1;
      step(1);
      bus.Halt = 1'b0;
      check_val("idle_coreen", {31'd0, bus.CoreEn}, 32'd0);
      check_val("idle_pcload", {31'd0, bus.PcLoad}, 32'd0);
      check_val("idle_ack",    {31'd0, bus.Ack},    32'd0);
      check_val("idle_count",  bus.CycleCount,      32'd0);
      bus.Start = 1'b1;
      step(1);
      check_val("idle_arm_pcload",  {31'd0, bus.PcLoad},  32'd1);
      check_val("idle_arm_pcstart", {22'd0, bus.PcStart}, 32'd128);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
